// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
// The FETCH_ALIGN_CHECK_EN macro (see fetch_unit.sv) enables misaligned-target trapping.
package fetch_unit_pkg;

    localparam int unsigned INSTR_BYTES      = 4;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_HOLD,
        ST_HALT
    } fetch_state_t;

    typedef enum logic [1:0] {
        PC_HOLD,
        PC_INC,
        PC_BR
    } pc_sel_t;

endpackage

// File: rtl/fetch_unit_pc_next.sv
// Next-PC selector for the fetch unit: sequential increment, redirect target, or hold.
// The increment wraps modulo 2^32 by construction of the 32-bit adder.
module pc_next
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] target,
    input  pc_sel_t     sel,
    output logic [31:0] next_pc
);

    always_comb begin
        case (sel)
            PC_INC:  next_pc = pc + 32'(INSTR_BYTES);
            PC_BR:   next_pc = target;
            default: next_pc = pc;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Single-outstanding instruction fetch FSM with redirect/kill handling and a decode holding slot.
// Define FETCH_ALIGN_CHECK_EN to trap misaligned redirect targets into HALT with a FetchMisalign pulse.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        NextPCSrc,
    input  logic [31:0] BrTarget,
    output logic        ImemReq,
    output logic [31:0] ImemAddr,
    input  logic        ImemReady,
    input  logic        ImemRvalid,
    input  logic [31:0] ImemRdata,
    output logic        InstValid,
    input  logic        InstReady,
    output logic [31:0] Inst,
    output logic [31:0] InstPC,
    output logic        FetchMisalign
);

    fetch_state_t state, state_nxt;
    pc_sel_t      pc_sel;
    logic [31:0]  pc, pc_nxt;
    logic [31:0]  target;
    logic [31:0]  inst_q, inst_pc_q;
    logic         kill, kill_nxt;
    logic         capture;
    logic         bad_target;

`ifdef FETCH_ALIGN_CHECK_EN
    logic misalign_q;

    assign target        = BrTarget;
    assign bad_target    = NextPCSrc && (BrTarget[1:0] != 2'b00);
    assign FetchMisalign = misalign_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= bad_target && (state != ST_HALT);
        end
    end
`else
    // Low address bits are forced to zero so every redirect stays word aligned.
    assign target        = BrTarget & ~32'h3;
    assign bad_target    = 1'b0;
    assign FetchMisalign = 1'b0;
`endif

    pc_next u_pc_next (
        .pc      (pc),
        .target  (target),
        .sel     (pc_sel),
        .next_pc (pc_nxt)
    );

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_nxt = state;
        kill_nxt  = kill;
        pc_sel    = PC_HOLD;
        capture   = 1'b0;

        if (bad_target && state != ST_HALT) begin
            state_nxt = ST_HALT;
            kill_nxt  = 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state_nxt = ST_REQ;
                    if (NextPCSrc) pc_sel = PC_BR;
                end
                ST_REQ: begin
                    if (NextPCSrc) pc_sel = PC_BR;
                    if (ImemReady) begin
                        state_nxt = ST_WAIT;
                        kill_nxt  = NextPCSrc;
                    end
                end
                ST_WAIT: begin
                    if (NextPCSrc) pc_sel = PC_BR;
                    if (ImemRvalid) begin
                        kill_nxt = 1'b0;
                        if (!kill && !NextPCSrc) begin
                            capture   = 1'b1;
                            pc_sel    = PC_INC;
                            state_nxt = ST_HOLD;
                        end else begin
                            state_nxt = ST_REQ;
                        end
                    end else if (NextPCSrc) begin
                        kill_nxt = 1'b1;
                    end
                end
                ST_HOLD: begin
                    // A redirect wins over InstReady; either way the held word is gone.
                    if (NextPCSrc) begin
                        pc_sel    = PC_BR;
                        state_nxt = ST_REQ;
                    end else if (InstReady) begin
                        state_nxt = ST_REQ;
                    end
                end
                ST_HALT: state_nxt = ST_HALT;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            pc        <= RESET_PC;
            kill      <= 1'b0;
            // NOTE: the instruction slot is reset because decode must see a known word after reset.
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            kill  <= kill_nxt;
            if (capture) begin
                inst_q    <= ImemRdata;
                inst_pc_q <= pc;
            end
        end
    end

    assign ImemReq   = (state == ST_REQ);
    assign ImemAddr  = pc;
    assign InstValid = (state == ST_HOLD);
    assign Inst      = inst_q;
    assign InstPC    = inst_pc_q;

    req_hold_exclusive: assert property (@(posedge clk) disable iff (!rst_n)
        !(ImemReq && InstValid));
    kill_only_waiting: assert property (@(posedge clk) disable iff (!rst_n)
        kill |-> (state == ST_WAIT));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, multi-cycle corner sequences,
// and a randomized run against a transaction-level fetch model.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;

    logic        clk;
    logic        rst_n;
    logic        NextPCSrc;
    logic [31:0] BrTarget;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemReady;
    logic        ImemRvalid;
    logic [31:0] ImemRdata;
    logic        InstValid;
    logic        InstReady;
    logic [31:0] Inst;
    logic [31:0] InstPC;
    logic        FetchMisalign;

    fetch_unit #(.RESET_PC(RST_PC)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .NextPCSrc     (NextPCSrc),
        .BrTarget      (BrTarget),
        .ImemReq       (ImemReq),
        .ImemAddr      (ImemAddr),
        .ImemReady     (ImemReady),
        .ImemRvalid    (ImemRvalid),
        .ImemRdata     (ImemRdata),
        .InstValid     (InstValid),
        .InstReady     (InstReady),
        .Inst          (Inst),
        .InstPC        (InstPC),
        .FetchMisalign (FetchMisalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic drive(input logic redir, input logic [31:0] tgt, input logic rdy,
                         input logic rv, input logic [31:0] rd, input logic ir);
        NextPCSrc  = redir;
        BrTarget   = tgt;
        ImemReady  = rdy;
        ImemRvalid = rv;
        ImemRdata  = rd;
        InstReady  = ir;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // Memory contents as a function of address, so delivered words can be checked by address.
    function automatic logic [31:0] fmem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
    endfunction

    typedef struct {
        logic        e_req;
        logic [31:0] e_addr;
        logic        e_iv;
        logic [31:0] e_inst;
        logic [31:0] e_ipc;
        logic        redir;
        logic [31:0] tgt;
        logic        rdy;
        logic        rv;
        logic [31:0] rd;
        logic        ir;
    } vec_t;

    vec_t vq[$];

    task automatic add(input logic e_req, input logic [31:0] e_addr, input logic e_iv,
                       input logic [31:0] e_inst, input logic [31:0] e_ipc,
                       input logic redir, input logic [31:0] tgt, input logic rdy,
                       input logic rv, input logic [31:0] rd, input logic ir);
        vec_t v;
        v.e_req = e_req; v.e_addr = e_addr; v.e_iv = e_iv; v.e_inst = e_inst; v.e_ipc = e_ipc;
        v.redir = redir; v.tgt = tgt; v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir;
        vq.push_back(v);
    endtask

    // Random-phase model state: one outstanding fetch, one delivered word awaiting decode.
    logic        outstanding, out_live, have_del, was_req;
    logic [31:0] out_addr, del_pc, exp_pc, t;
    logic        r_rdy, r_redir, r_ir, r_rv;
    logic [31:0] r_rd;
    int          lat;
    int          n_delivered;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1);
    end

    initial begin
        do_reset();
        check1("reset req", ImemReq, 1'b0);
        check("reset addr", ImemAddr, RST_PC);
        check1("reset iv", InstValid, 1'b0);
        check("reset inst", Inst, 32'h0);
        check("reset ipc", InstPC, 32'h0);
        check1("reset misalign", FetchMisalign, 1'b0);

        // Expected outputs before the edge, then the inputs applied for that edge.
        add(0, 32'h000, 0, 32'h0,         32'h0,   0, 32'h0,   1, 1, 32'hBAD0_0000, 1);
        add(1, 32'h000, 0, 32'h0,         32'h0,   0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h000, 0, 32'h0,         32'h0,   0, 32'h0,   1, 1, 32'h1111_0000, 1);
        add(0, 32'h004, 1, 32'h1111_0000, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1);
        add(1, 32'h004, 0, 32'h1111_0000, 32'h0,   0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h004, 0, 32'h1111_0000, 32'h0,   0, 32'h0,   1, 1, 32'h2222_0000, 1);
        add(0, 32'h008, 1, 32'h2222_0000, 32'h4,   0, 32'h0,   1, 0, 32'h0,         1);
        add(1, 32'h008, 0, 32'h2222_0000, 32'h4,   0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h008, 0, 32'h2222_0000, 32'h4,   1, 32'h100, 0, 0, 32'h0,         1);
        add(0, 32'h100, 0, 32'h2222_0000, 32'h4,   0, 32'h0,   0, 1, 32'hDEAD_BEEF, 1);
        add(1, 32'h100, 0, 32'h2222_0000, 32'h4,   0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h100, 0, 32'h2222_0000, 32'h4,   0, 32'h0,   1, 1, 32'h3333_0000, 1);
        add(0, 32'h104, 1, 32'h3333_0000, 32'h100, 0, 32'h0,   1, 0, 32'h0,         1);
        add(1, 32'h104, 0, 32'h3333_0000, 32'h100, 1, 32'h200, 1, 0, 32'h0,         1);
        add(0, 32'h200, 0, 32'h3333_0000, 32'h100, 0, 32'h0,   1, 1, 32'h4444_0000, 1);
        add(1, 32'h200, 0, 32'h3333_0000, 32'h100, 1, 32'h300, 0, 0, 32'h0,         1);
        add(1, 32'h300, 0, 32'h3333_0000, 32'h100, 0, 32'h0,   0, 0, 32'h0,         1);
        add(1, 32'h300, 0, 32'h3333_0000, 32'h100, 0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h300, 0, 32'h3333_0000, 32'h100, 1, 32'h400, 1, 1, 32'h5555_0000, 1);
        add(1, 32'h400, 0, 32'h3333_0000, 32'h100, 0, 32'h0,   1, 0, 32'h0,         1);
        add(0, 32'h400, 0, 32'h3333_0000, 32'h100, 0, 32'h0,   1, 1, 32'h6666_0000, 1);
        add(0, 32'h404, 1, 32'h6666_0000, 32'h400, 1, 32'h500, 1, 0, 32'h0,         1);
        add(1, 32'h500, 0, 32'h6666_0000, 32'h400, 0, 32'h0,   0, 0, 32'h0,         0);

        for (int i = 0; i < vq.size(); i++) begin
            check1($sformatf("vec%0d req", i), ImemReq, vq[i].e_req);
            check($sformatf("vec%0d addr", i), ImemAddr, vq[i].e_addr);
            check1($sformatf("vec%0d iv", i), InstValid, vq[i].e_iv);
            check($sformatf("vec%0d inst", i), Inst, vq[i].e_inst);
            check($sformatf("vec%0d ipc", i), InstPC, vq[i].e_ipc);
            check1($sformatf("vec%0d misalign", i), FetchMisalign, 1'b0);
            drive(vq[i].redir, vq[i].tgt, vq[i].rdy, vq[i].rv, vq[i].rd, vq[i].ir);
            tick();
        end

        // Decode stall: the held word must not move and no new request may issue.
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 32'h0, 1, 1, 32'hA5A5_0001, 0);
        tick();
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) begin
            check1($sformatf("stall%0d iv", i), InstValid, 1'b1);
            check($sformatf("stall%0d inst", i), Inst, 32'hA5A5_0001);
            check($sformatf("stall%0d ipc", i), InstPC, 32'h500);
            check1($sformatf("stall%0d req", i), ImemReq, 1'b0);
            tick();
        end
        drive(0, 32'h0, 0, 0, 32'h0, 1);
        tick();
        check1("stall release iv", InstValid, 1'b0);
        check1("stall release req", ImemReq, 1'b1);
        check("stall release addr", ImemAddr, 32'h504);

        // PC wrap at the top of the address space.
        drive(1, 32'hFFFF_FFFC, 0, 0, 32'h0, 0);
        tick();
        check("wrap redirect addr", ImemAddr, 32'hFFFF_FFFC);
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        tick();
        drive(0, 32'h0, 1, 1, 32'h0BAD_F00D, 0);
        tick();
        check("wrap ipc", InstPC, 32'hFFFF_FFFC);
        check("wrap inst", Inst, 32'h0BAD_F00D);
        drive(0, 32'h0, 0, 0, 32'h0, 1);
        tick();
        check1("wrap next req", ImemReq, 1'b1);
        check("wrap next addr", ImemAddr, 32'h0);

        // Reset while a response is outstanding; the stale response arrives after release.
        drive(0, 32'h0, 1, 0, 32'h0, 0);
        tick();
        check1("rstwait in wait", ImemReq, 1'b0);
        rst_n = 1'b0;
        drive(1, 32'h40, 0, 0, 32'h0, 0);
        tick();
        check1("rstwait req", ImemReq, 1'b0);
        check("rstwait addr", ImemAddr, RST_PC);
        check1("rstwait iv", InstValid, 1'b0);
        check("rstwait inst", Inst, 32'h0);
        check("rstwait ipc", InstPC, 32'h0);
        rst_n = 1'b1;
        drive(0, 32'h0, 0, 1, 32'hBAD0_0001, 1);
        tick();
        check1("rstwait idle resp req", ImemReq, 1'b1);
        check("rstwait idle resp addr", ImemAddr, RST_PC);
        check1("rstwait idle resp iv", InstValid, 1'b0);
        tick();
        check1("rstwait req resp req", ImemReq, 1'b1);
        check("rstwait req resp addr", ImemAddr, RST_PC);
        check1("rstwait req resp iv", InstValid, 1'b0);
        drive(0, 32'h0, 1, 0, 32'h0, 1);
        tick();
        drive(0, 32'h0, 1, 1, 32'h7777_0000, 1);
        tick();
        check1("rstwait fetch iv", InstValid, 1'b1);
        check("rstwait fetch inst", Inst, 32'h7777_0000);
        check("rstwait fetch ipc", InstPC, RST_PC);

        // Randomized run against a transaction-level model of the fetch stream.
        do_reset();
        tick();
        outstanding = 1'b0; out_live = 1'b0; have_del = 1'b0;
        out_addr = '0; del_pc = '0; exp_pc = RST_PC; lat = 0; n_delivered = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            r_rdy   = ($urandom_range(3) != 0);
            r_redir = ($urandom_range(9) == 0);
            r_ir    = ($urandom_range(2) != 0);
            t = $urandom;
            t[1:0] = 2'b00;
            if ($urandom_range(7) == 0) t = 32'hFFFF_FFF0 | (t & 32'hC);
            r_rv = outstanding && (lat == 0);
            r_rd = r_rv ? fmem(out_addr) : $urandom;

            was_req = !outstanding && !have_del;
            check1("rnd req", ImemReq, was_req);
            check1("rnd iv", InstValid, have_del);
            if (was_req) check("rnd addr", ImemAddr, exp_pc);
            if (have_del) begin
                check("rnd ipc", InstPC, del_pc);
                check("rnd inst", Inst, fmem(del_pc));
            end

            drive(r_redir, t, r_rdy, r_rv, r_rd, r_ir);

            if (have_del && r_ir) begin
                n_delivered++;
                have_del = 1'b0;
            end
            if (r_rv) begin
                outstanding = 1'b0;
                if (out_live && !r_redir) begin
                    have_del = 1'b1;
                    del_pc   = out_addr;
                    exp_pc   = out_addr + 32'd4;
                end
            end else if (outstanding) begin
                lat--;
            end else if (was_req && r_rdy) begin
                outstanding = 1'b1;
                out_addr    = exp_pc;
                out_live    = 1'b1;
                lat         = $urandom_range(2);
            end
            if (r_redir) begin
                exp_pc   = t;
                have_del = 1'b0;
                out_live = 1'b0;
            end
            tick();
        end
        check1("rnd progress", n_delivered >= 50, 1'b1);

        // Misaligned redirect target.
        do_reset();
        tick();
        drive(1, 32'h102, 0, 0, 32'h0, 0);
        tick();
`ifdef FETCH_ALIGN_CHECK_EN
        check1("misalign pulse", FetchMisalign, 1'b1);
        check1("misalign req", ImemReq, 1'b0);
        check1("misalign iv", InstValid, 1'b0);
        for (int i = 0; i < 6; i++) begin
            drive(i == 2, 32'h200, 1, 0, 32'h0, 1);
            tick();
            check1($sformatf("halt%0d misalign", i), FetchMisalign, 1'b0);
            check1($sformatf("halt%0d req", i), ImemReq, 1'b0);
            check1($sformatf("halt%0d iv", i), InstValid, 1'b0);
        end
`else
        check1("misalign tied", FetchMisalign, 1'b0);
        check1("misalign req", ImemReq, 1'b1);
        check("misalign addr", ImemAddr, 32'h100);
`endif
        do_reset();
        tick();
        check1("recover req", ImemReq, 1'b1);
        check("recover addr", ImemAddr, RST_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
